// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: segment codes (a..g, active-low),
// the all-off pattern, and a width helper that never returns zero.
package seg7_pkg;

    localparam logic [0:6] SEG_BLANK = 7'b1111111;

    localparam logic [0:6] SEG_CODE [0:15] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Hex nibble to active-low a..g segment pattern; purely combinational, no handshake.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [0:6] o_seg
);

    assign o_seg = SEG_CODE[i_nib];

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed N-digit common-anode driver with frame-synchronous value commit.
// Outputs are registered one cycle behind the scan position; no backpressure, load is a strobe.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int GHOST_CYCLES = 2
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [4*NUM_DIGITS-1:0] i_value,
    input  logic                    i_load,
    input  logic [NUM_DIGITS-1:0]   i_dp_in,
    input  logic [NUM_DIGITS-1:0]   i_digit_en,
    input  logic                    i_lz_blank,
    output logic [0:6]              o_seg,
    output logic                    o_dp,
    output logic [NUM_DIGITS-1:0]   o_an,
    output logic                    o_frame_done
);

    localparam int IDX_W = idx_w(NUM_DIGITS);
    localparam int CNT_W = idx_w(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_GHOST = CNT_W'(GHOST_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_pend_val;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic                    r_pend_vld;
    logic [4*NUM_DIGITS-1:0] r_disp_val;
    logic [NUM_DIGITS-1:0]   r_disp_dp;
    logic [0:6]              r_seg;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_frame_done;

    logic                    w_slot_end;
    logic                    w_commit;
    logic [3:0]              w_nib;
    logic                    w_dp_sel;
    logic                    w_cur_blank;
    logic                    w_hi_zero;
    logic [NUM_DIGITS-1:0]   w_an_sel;
    logic [0:6]              w_seg;

    assign w_slot_end = (r_cnt == CNT_LAST);
    assign w_commit   = w_slot_end && (r_idx == IDX_LAST);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Display only changes at the frame boundary so a frame never mixes old and new digits.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pend_val <= '0;
            r_pend_dp  <= '0;
            r_pend_vld <= 1'b0;
            r_disp_val <= '0;
            r_disp_dp  <= '0;
        end else if (w_commit) begin
            if (i_load) begin
                r_disp_val <= i_value;
                r_disp_dp  <= i_dp_in;
            end else if (r_pend_vld) begin
                r_disp_val <= r_pend_val;
                r_disp_dp  <= r_pend_dp;
            end
            r_pend_vld <= 1'b0;
        end else if (i_load) begin
            r_pend_val <= i_value;
            r_pend_dp  <= i_dp_in;
            r_pend_vld <= 1'b1;
        end
    end

    // Walk from the top digit down so w_hi_zero means "this nibble and all above are zero".
    always_comb begin
        w_nib       = '0;
        w_dp_sel    = 1'b0;
        w_cur_blank = 1'b1;
        w_an_sel    = '1;
        w_hi_zero   = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_hi_zero = w_hi_zero && (r_disp_val[4*k +: 4] == 4'h0);
            if (r_idx == IDX_W'(k)) begin
                w_nib       = r_disp_val[4*k +: 4];
                w_dp_sel    = r_disp_dp[k];
                w_cur_blank = !i_digit_en[k] || (i_lz_blank && w_hi_zero && (k != 0));
                w_an_sel[k] = 1'b0;
            end
        end
    end

    seg7_decode u_decode (
        .i_nib (w_nib),
        .o_seg (w_seg)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_seg        <= SEG_BLANK;
            r_dp         <= 1'b1;
            r_an         <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_commit;
            if ((r_cnt < CNT_GHOST) || w_cur_blank) begin
                r_seg <= SEG_BLANK;
                r_dp  <= 1'b1;
                r_an  <= '1;
            end else begin
                r_seg <= w_seg;
                r_dp  <= ~w_dp_sel;
                r_an  <= w_an_sel;
            end
        end
    end

    assign o_seg        = r_seg;
    assign o_dp         = r_dp;
    assign o_an         = r_an;
    assign o_frame_done = r_frame_done;

endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
- Parametrised, time-multiplexed driver for an N-digit common-anode seven-segment display.
- Successor to the single-nibble hex-to-segment decoder; it shares that decoder's segment codes.
- Adds per-digit scanning, a refresh divider, anti-ghost blanking, leading-zero suppression, per-digit decimal points and tear-free frame-synchronous value updates.
- Sits between a datapath result register and the board's segment and anode pins.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; legal range 1..8.
- REFRESH_DIV, 100000: clk cycles per digit slot; must be at least GHOST_CYCLES+1.
- GHOST_CYCLES, 2: cycles at the start of each slot during which all anodes are held off.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- value  in  4*NUM_DIGITS  hex nibbles; nibble k drives digit k, digit 0 is rightmost.
- load  in  1  strobe; captures value and dp_in into the pending register.
- dp_in  in  NUM_DIGITS  decimal-point request per digit, active-high.
- digit_en  in  NUM_DIGITS  per-digit enable; 0 blanks that digit.
- lz_blank  in  1  1 enables leading-zero suppression.
- seg  out  [0:6]  segments a..g, active-low.
- dp  out  1  decimal point, active-low.
- an  out  NUM_DIGITS  anodes, active-low, one-hot-low while lit.
- frame_done  out  1  one-cycle pulse per completed frame.

Interface rule: one clock; reset is synchronous and active-high.

Behaviour:
- Reset values: seg=7'b1111111, dp=1, an=all ones, frame_done=0. Slot counter cnt=0, digit index idx=0, pending and display registers=0, pending-valid flag=0.
- Reset asserted mid-operation takes effect at the next clk edge; scanning restarts at digit 0.
- cnt counts 0..REFRESH_DIV-1. At REFRESH_DIV-1, cnt wraps to 0 and idx increments modulo NUM_DIGITS.
- load=1 copies value and dp_in into the pending register and sets pending-valid. A later load before commit overwrites pending.
- Commit (terminal cycle: idx=NUM_DIGITS-1 and cnt=REFRESH_DIV-1):
  - If pending-valid, pending copies into the display register and pending-valid clears.
  - If load is high in the commit cycle, the incoming value bypasses pending and is committed directly.
  - frame_done is high in the cycle after the commit cycle.
- Leading-zero suppression (lz_blank=1): digit k is blank if every display nibble at index >=k is 0 and k>0. Digit 0 is never suppressed.
- A digit is blank if it is suppressed or digit_en[k]=0.
- Outputs are registered and reflect (idx, cnt) of the previous cycle, giving 1-cycle latency:
  - cnt < GHOST_CYCLES, or current digit blank: an=all ones, seg=7'b1111111, dp=1.
  - Otherwise: an has bit idx=0 and all others 1; seg=decode(nibble idx); dp=~dp_in_display[idx].
- Segment codes 0..F: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100, 0001000, 1100000, 0110001, 1000010, 0110000, 0111000.
- NUM_DIGITS=1: idx stays 0 and commit occurs every slot.

Decomposition:
- Package seg7_pkg holds:
  - the SEG_CODE[0:15] constant table;
  - SEG_BLANK=7'b1111111;
  - the IDX_W = clog2 width helper.
- One sub-module, seg7_decode: combinational 4-bit nibble in, [0:6] active-low segments out. It is instantiated once, on the muxed nibble.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4, GHOST_CYCLES=1; slot = 1 dark cycle + 3 lit cycles):
- Reset held 3 cycles -> seg=7'b1111111, an=4'b1111, dp=1, frame_done=0. After release, the first lit cycle shows digit 0 as "0": seg=0000001, an=1110.
- Load 16'h12AF, lz_blank=0, digit_en=4'b1111; after the next commit:
  - slot 0: seg=0111000, an=1110;
  - slot 1: seg=0001000, an=1101;
  - slot 2: seg=0010010, an=1011;
  - slot 3: seg=1001111, an=0111;
  - frame_done pulses every 16 cycles.
- lz_blank=1 with value 16'h0030:
  - digits 3 and 2 keep an high for their whole slot;
  - digit 1 shows seg=0000110;
  - digit 0 shows 0000001.
- lz_blank=1 with value 16'h0000: only digit 0 lights.
- Tear-free update:
  - Load 16'h1111 during slot 1 of a 16'h12AF frame -> slots 2 and 3 still show 2 and 1, and all digits show 1 from the next frame.
  - Load coincident with the commit cycle -> the new value is displayed from the next frame.
- dp_in=4'b0010, digit_en=4'b1011:
  - dp=0 only during digit 1's lit cycles;
  - an stays 4'b1111 throughout slot 2.
- Assert reset during slot 2 -> outputs return to reset values on the next edge. After release, the scan restarts at digit 0 showing "0" and the previously loaded value is lost.
